// File: rtl/seq_subtractor.sv
// Digit-serial subtractor: computes a - b - bin one STEP-bit digit per clock,
// LSB digit first, and reports difference, borrow-out, zero and signed overflow.
module seq_subtractor #(
   parameter int WIDTH = 16,
   parameter int STEP  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic             b_out,
   output logic             zero,
   output logic             ovf
);

   localparam int N     = WIDTH / STEP;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             a_msb_q, a_msb_d;
   logic             b_msb_q, b_msb_d;
   logic             borrow_q, borrow_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic             b_out_q, b_out_d;
   logic             zero_q, zero_d;
   logic             ovf_q, ovf_d;
   logic             done_q, done_d;
   logic [STEP:0]    sub;

   always_comb begin
      // NOTE: every signal assigned here gets a default first so no latch is inferred.
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      a_msb_d  = a_msb_q;
      b_msb_d  = b_msb_q;
      borrow_d = borrow_q;
      cnt_d    = cnt_q;
      diff_d   = diff_q;
      d_d      = d_q;
      b_out_d  = b_out_q;
      zero_d   = zero_q;
      ovf_d    = ovf_q;
      done_d   = 1'b0;

      // Low digit of the shifting operands; the top bit of sub is the digit borrow.
      sub = {1'b0, a_q[STEP-1:0]} - {1'b0, b_q[STEP-1:0]} - {{STEP{1'b0}}, borrow_q};

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d      = a;
               b_d      = b;
               a_msb_d  = a[WIDTH-1];
               b_msb_d  = b[WIDTH-1];
               borrow_d = bin;
               cnt_d    = '0;
               diff_d   = '0;
               state_d  = BUSY;
            end
         end
         BUSY: begin
            a_d      = a_q >> STEP;
            b_d      = b_q >> STEP;
            borrow_d = sub[STEP];
            // New digit enters at the top; after N digits the LSB digit sits at bit 0.
            diff_d   = (diff_q >> STEP) | (WIDTH'(sub[STEP-1:0]) << (WIDTH - STEP));
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               d_d     = diff_d;
               b_out_d = sub[STEP];
               zero_d  = (diff_d == '0);
               ovf_d   = (a_msb_q != b_msb_q) && (diff_d[WIDTH-1] != a_msb_q);
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; the reset clears
   // every register, including the operand copies, since they are few and cheap.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         borrow_q <= 1'b0;
         cnt_q    <= '0;
         diff_q   <= '0;
         d_q      <= '0;
         b_out_q  <= 1'b0;
         zero_q   <= 1'b1;
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         a_msb_q  <= a_msb_d;
         b_msb_q  <= b_msb_d;
         borrow_q <= borrow_d;
         cnt_q    <= cnt_d;
         diff_q   <= diff_d;
         d_q      <= d_d;
         b_out_q  <= b_out_d;
         zero_q   <= zero_d;
         ovf_q    <= ovf_d;
         done_q   <= done_d;
      end
   end

   assign ready = (state_q == IDLE);
   assign done  = done_q;
   assign d     = d_q;
   assign b_out = b_out_q;
   assign zero  = zero_q;
   assign ovf   = ovf_q;

endmodule

// File: tb/tb_seq_subtractor.sv
// Directed bench for seq_subtractor (WIDTH=16, STEP=4): hand-computed results,
// latency, start-while-busy, reset abort and back-to-back throughput.
module tb_seq_subtractor;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        bin;
   logic        ready;
   logic        done;
   logic [15:0] d;
   logic        b_out;
   logic        zero;
   logic        ovf;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          done_cnt = 0;
   logic [15:0] last_d;

   seq_subtractor #(.WIDTH(16), .STEP(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .ready (ready),
      .done  (done),
      .d     (d),
      .b_out (b_out),
      .zero  (zero),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done === 1'b1) done_cnt++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Full operation with latency, mid-operation hold and single-pulse checks.
   task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic tbin, input logic [15:0] ed, input logic eb,
                         input logic ez, input logic eo);
      int lat;
      @(negedge clk);
      a = ta; b = tb_v; bin = tbin; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0;
      while (lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (lat == 1) begin
            check({tag, "_busy_ready"}, 32'(ready), 32'(0));
            check({tag, "_hold_d"}, 32'(d), 32'(last_d));
         end
         if (done === 1'b1) break;
      end
      check({tag, "_latency"}, 32'(lat), 32'(4));
      check({tag, "_d"}, 32'(d), 32'(ed));
      check({tag, "_bout"}, 32'(b_out), 32'(eb));
      check({tag, "_zero"}, 32'(zero), 32'(ez));
      check({tag, "_ovf"}, 32'(ovf), 32'(eo));
      @(negedge clk);
      check({tag, "_done_1cyc"}, 32'(done), 32'(0));
      check({tag, "_ready"}, 32'(ready), 32'(1));
      check({tag, "_d_held"}, 32'(d), 32'(ed));
      last_d = ed;
   endtask

   initial begin
      int          dc0;
      logic        seen;
      logic [15:0] va [3];
      logic [15:0] vb [3];
      logic [15:0] vd [3];
      logic        vbo [3];
      logic        vov [3];
      longint      t_done [3];

      rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_ready", 32'(ready), 32'(1));
      check("rst_done", 32'(done), 32'(0));
      check("rst_d", 32'(d), 32'(0));
      check("rst_bout", 32'(b_out), 32'(0));
      check("rst_zero", 32'(zero), 32'(1));
      check("rst_ovf", 32'(ovf), 32'(0));
      last_d = 16'h0000;

      run_op("basic", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
      run_op("under", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
      run_op("bin",   16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
      run_op("ovf",   16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1);
      run_op("zero",  16'hABCD, 16'hABCD, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);

      // Operand changes after capture and a start pulse during BUSY are ignored.
      dc0 = done_cnt;
      @(negedge clk);
      a = 16'h1234; b = 16'h0234; bin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0; a = 16'h5555; b = 16'h1111; bin = 1'b1;
      @(negedge clk);
      @(negedge clk);
      start = 1'b1; a = 16'hFFFF; b = 16'h0001;
      @(posedge clk);
      #1 start = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
      end
      check("busy_start_done_seen", 32'(seen), 32'(1));
      check("busy_start_d", 32'(d), 32'(16'h1000));
      check("busy_start_bout", 32'(b_out), 32'(0));
      repeat (8) @(negedge clk);
      check("busy_start_one_done", 32'(done_cnt - dc0), 32'(1));
      check("busy_start_idle", 32'(ready), 32'(1));

      // Reset on the second BUSY edge aborts the operation.
      dc0 = done_cnt;
      @(negedge clk);
      a = 16'h00FF; b = 16'h000F; bin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("abort_ready", 32'(ready), 32'(1));
      check("abort_done", 32'(done), 32'(0));
      check("abort_d", 32'(d), 32'(0));
      check("abort_bout", 32'(b_out), 32'(0));
      check("abort_zero", 32'(zero), 32'(1));
      check("abort_ovf", 32'(ovf), 32'(0));
      repeat (6) @(negedge clk);
      check("abort_no_done", 32'(done_cnt - dc0), 32'(0));
      last_d = 16'h0000;
      run_op("after_abort", 16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0);

      // Back-to-back: start held high, next operands presented in each done cycle.
      va[0] = 16'h1111; vb[0] = 16'h0001; vd[0] = 16'h1110; vbo[0] = 1'b0; vov[0] = 1'b0;
      va[1] = 16'h0100; vb[1] = 16'h0200; vd[1] = 16'hFF00; vbo[1] = 1'b1; vov[1] = 1'b0;
      va[2] = 16'h7FFF; vb[2] = 16'hFFFF; vd[2] = 16'h8000; vbo[2] = 1'b1; vov[2] = 1'b1;
      @(negedge clk);
      a = va[0]; b = vb[0]; bin = 1'b0; start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         seen = 1'b0;
         for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
         end
         t_done[i] = longint'($time);
         check($sformatf("b2b%0d_seen", i), 32'(seen), 32'(1));
         check($sformatf("b2b%0d_d", i), 32'(d), 32'(vd[i]));
         check($sformatf("b2b%0d_bout", i), 32'(b_out), 32'(vbo[i]));
         check($sformatf("b2b%0d_ovf", i), 32'(ovf), 32'(vov[i]));
         if (i < 2) begin
            a = va[i+1]; b = vb[i+1];
         end else begin
            start = 1'b0;
         end
      end
      check("b2b_gap01", 32'((t_done[1] - t_done[0]) / 10), 32'(5));
      check("b2b_gap12", 32'((t_done[2] - t_done[1]) / 10), 32'(5));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_subtractor.md
SEQ_SUBTRACTOR -- requirements
Module: seq_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand/result width in bits.
REQ-002 The block SHALL have parameter STEP, default 4, meaning bits subtracted per cycle.
REQ-003 The block SHALL require WIDTH to be an exact multiple of STEP, with STEP >= 1. N = WIDTH/STEP.
REQ-004 The block SHALL have port clk, input, 1, the single clock, rising-edge.
REQ-005 The block SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-006 The block SHALL have port start, input, 1, which requests an operation.
REQ-007 The block SHALL have ports a and b, input, WIDTH each, for minuend and subtrahend.
REQ-008 The block SHALL have port bin, input, 1, the borrow-in.
REQ-009 The block SHALL have port ready, output, 1, which is high when idle and able to accept start.
REQ-010 The block SHALL have port done, output, 1, a one-cycle result-valid pulse.
REQ-011 The block SHALL have port d, output, WIDTH, the difference a - b - bin modulo 2^WIDTH.
REQ-012 The block SHALL have port b_out, output, 1, the borrow-out, which is 1 when a < b + bin as unsigned values.
REQ-013 The block SHALL have port zero, output, 1, which is 1 when d == 0.
REQ-014 The block SHALL have port ovf, output, 1, the two's-complement signed overflow of a - b - bin.

Function
REQ-015 The FSM SHALL have exactly two states, IDLE and BUSY, with ready = 1 only in IDLE.
REQ-016 In IDLE, start = 1 at a rising edge SHALL capture a, b and bin into internal registers, clear the digit counter to 0, and move the FSM to BUSY.
REQ-017 start SHALL be ignored while in BUSY, and an in-flight operation SHALL NOT be disturbed.
REQ-018 Operand changes after the capture edge SHALL NOT affect the result.
REQ-019 Each BUSY edge SHALL process one STEP-bit digit, LSB digit first, as {borrow, digit_k} = a_k - b_k - borrow.
REQ-020 The running borrow SHALL be initialised to the captured bin.
REQ-021 The partial difference SHALL be held internally, and d SHALL NOT change during BUSY.
REQ-022 On the edge that processes digit N-1, the block SHALL:
- load d, b_out, zero and ovf;
- pulse done to 1;
- return the FSM to IDLE, with ready = 1.
REQ-023 Latency SHALL be exactly N cycles: done is high in the cycle following the N-th edge after the capture edge.
REQ-024 done SHALL be high for exactly one cycle per operation.
REQ-025 Throughput SHALL be one operation per N+1 cycles: start may be accepted on the edge immediately after the done cycle begins.
REQ-026 ovf SHALL equal (a[MSB] != b[MSB]) && (d[MSB] != a[MSB]), using the captured operands.
REQ-027 d, b_out, zero and ovf SHALL hold their last values until the next completing edge or reset.
REQ-028 With STEP == WIDTH (N = 1), the block SHALL complete in one BUSY edge under the same rules.

Reset
REQ-029 When rst = 1 at a rising edge, the block SHALL:
- force IDLE;
- clear the counter, borrow and internal operand registers;
- set d = 0, b_out = 0, ovf = 0, done = 0;
- set zero = 1 and ready = 1.
REQ-030 rst SHALL take priority over start on the same edge.
REQ-031 rst asserted during BUSY SHALL abort the operation, with no done pulse and the outputs taking their reset values.

Verification (WIDTH=16, STEP=4)
REQ-032 The bench SHALL apply start with a=0x1234, b=0x0234, bin=0 and check:
- done exactly 4 cycles after capture;
- d=0x1000, b_out=0, zero=0, ovf=0.
REQ-033 The bench SHALL apply a=0x0000, b=0x0001, bin=0 and check d=0xFFFF, b_out=1, ovf=0; then apply a=0x0005, b=0x0005, bin=1 and check d=0xFFFF, b_out=1.
REQ-034 The bench SHALL apply a=0x8000, b=0x0001, bin=0 and check d=0x7FFF, b_out=0, ovf=1; then apply a=0xABCD, b=0xABCD, bin=0 and check d=0x0000, zero=1.
REQ-035 The bench SHALL pulse start with new operands during BUSY and change a and b after capture, and check that the result matches the first captured operands and that only one done pulse occurs.
REQ-036 The bench SHALL assert rst on the 2nd BUSY edge and check no done pulse, all outputs at reset values, and ready=1; then check that a subsequent operation completes correctly.
REQ-037 The bench SHALL drive back-to-back starts and check done pulses spaced exactly 5 cycles apart, with each result correct.
